// File: rtl/cpu_seq_pkg.sv
// Shared encodings for the multicycle CPU sequencer: FSM states, branch codes and
// the default memory-response timeout.
package cpu_seq_pkg;

    typedef enum logic [2:0] {
        StIdle   = 3'd0,
        StFetch  = 3'd1,
        StDecode = 3'd2,
        StExec   = 3'd3,
        StMem    = 3'd4,
        StWb     = 3'd5,
        StTrap   = 3'd6
    } state_e;

    localparam logic [2:0] BrNone = 3'b000;
    localparam logic [2:0] BrJal  = 3'b001;
    localparam logic [2:0] BrJalr = 3'b010;
    // Any code with bit 2 set is a conditional branch resolved by br_taken.
    localparam int unsigned BrCondBit = 2;

    localparam int unsigned DefaultTimeout = 255;

endpackage

// File: rtl/cpu_seq_if.sv
// Memory request bus between the sequencer (master) and the memory system (slave).
interface cpu_seq_if;

    logic mem_req;
    logic mem_we;
    logic mem_addr_sel;
    logic mem_gnt;
    logic mem_rvalid;

    modport master (
        output mem_req,
        output mem_we,
        output mem_addr_sel,
        input  mem_gnt,
        input  mem_rvalid
    );

    modport slave (
        input  mem_req,
        input  mem_we,
        input  mem_addr_sel,
        output mem_gnt,
        output mem_rvalid
    );

endinterface

// File: rtl/seq_mem_port.sv
// req/gnt/rvalid handshake with response timer, shared by instruction fetch and data access.
module seq_mem_port
    import cpu_seq_pkg::*;
#(
    parameter int unsigned TIMEOUT = DefaultTimeout
) (
    input  logic clk,
    input  logic rst_n,
    input  logic active,
    input  logic gnt,
    input  logic rvalid,
    output logic req,
    output logic accept,
    output logic timeout
);

    localparam logic [7:0] TimerLimit = 8'(TIMEOUT - 1);

    logic       granted_q;
    logic [7:0] timer_q;

    // Leaving the FETCH/MEM state clears the handshake, so each new request starts fresh.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            granted_q <= 1'b0;
            timer_q   <= '0;
        end else if (!active) begin
            granted_q <= 1'b0;
            timer_q   <= '0;
        end else begin
            if (req && gnt) begin
                granted_q <= 1'b1;
            end
            if (timer_q != 8'hFF) begin
                timer_q <= timer_q + 8'd1;
            end
        end
    end

    assign req     = active && !granted_q;
    // rvalid only counts once the grant has been registered.
    assign accept  = active && granted_q && rvalid;
    assign timeout = active && !accept && (timer_q >= TimerLimit);

endmodule

// File: rtl/cpu_seq.sv
// Multicycle CPU control sequencer: FETCH/DECODE/EXEC/MEM/WB with sticky trap on
// illegal instructions or memory timeout.
module cpu_seq
    import cpu_seq_pkg::*;
#(
    parameter int unsigned TIMEOUT = DefaultTimeout,
    parameter int unsigned CNT_W   = 32
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic             start,
    input  logic             dec_reg_write,
    input  logic             dec_mem_write,
    input  logic             dec_load,
    input  logic [2:0]       dec_branch,
    input  logic             br_taken,
    cpu_seq_if.master        mem,
    output logic             ir_we,
    output logic             rf_we,
    output logic             pc_we,
    output logic             pc_sel,
    output logic [2:0]       state,
    output logic             trap,
    output logic [CNT_W-1:0] retire_cnt
);

    state_e           state_q, state_d;
    logic [CNT_W-1:0] retire_cnt_q;
    logic             port_active, port_req, port_accept, port_timeout;
    logic             in_wb, illegal, jump, cond_taken;

    assign port_active = (state_q == StFetch) || (state_q == StMem);

    seq_mem_port #(
        .TIMEOUT(TIMEOUT)
    ) u_mem_port (
        .clk    (clk),
        .rst_n  (rst_n),
        .active (port_active),
        .gnt    (mem.mem_gnt),
        .rvalid (mem.mem_rvalid),
        .req    (port_req),
        .accept (port_accept),
        .timeout(port_timeout)
    );

    assign illegal    = !dec_reg_write && !dec_mem_write && (dec_branch == BrNone);
    assign jump       = (dec_branch == BrJal) || (dec_branch == BrJalr);
    assign cond_taken = dec_branch[BrCondBit] && br_taken;

    always_comb begin
        state_d = state_q;
        unique case (state_q)
            StIdle:   if (start) state_d = StFetch;
            StFetch: begin
                if (port_accept)       state_d = StDecode;
                else if (port_timeout) state_d = StTrap;
            end
            StDecode: state_d = illegal ? StTrap : StExec;
            StExec:   state_d = (dec_load || dec_mem_write) ? StMem : StWb;
            StMem: begin
                if (port_accept)       state_d = StWb;
                else if (port_timeout) state_d = StTrap;
            end
            StWb:     state_d = StFetch;
            StTrap:   state_d = StTrap;
            default:  state_d = StTrap;
        endcase
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q      <= StIdle;
            retire_cnt_q <= '0;
        end else begin
            state_q <= state_d;
            if (state_q == StWb) begin
                retire_cnt_q <= retire_cnt_q + CNT_W'(1);
            end
        end
    end

    assign in_wb = (state_q == StWb);

    assign mem.mem_req      = port_req;
    assign mem.mem_we       = (state_q == StMem) && dec_mem_write;
    assign mem.mem_addr_sel = (state_q == StMem);

    assign ir_we      = (state_q == StFetch) && port_accept;
    assign rf_we      = in_wb && dec_reg_write;
    assign pc_we      = in_wb;
    assign pc_sel     = in_wb && (jump || cond_taken);
    assign state      = state_q;
    assign trap       = (state_q == StTrap);
    assign retire_cnt = retire_cnt_q;

endmodule

// File: doc/cpu_seq.md
CPU_SEQ -- requirements
Module: cpu_seq

Interface
REQ-001 Parameter TIMEOUT, default 255, is the maximum cycles from mem_req assertion to mem_rvalid before trapping; range 1..255.
REQ-002 Parameter CNT_W, default 32, is the width of retire_cnt.
REQ-003 clk  in  1  single clock; all state updates on the rising edge.
REQ-004 rst_n  in  1  asynchronous, active-low reset.
REQ-005 start  in  1  leave IDLE and begin fetching; sampled only in IDLE.
REQ-006 dec_reg_write  in  1  decoded register-write flag of the current instruction.
REQ-007 dec_mem_write  in  1  decoded store flag.
REQ-008 dec_load  in  1  decoded load flag (write-data source bit 2).
REQ-009 dec_branch  in  3  decoded branch code: 000 none, 001 jal, 010 jalr, 1xx conditional.
REQ-010 br_taken  in  1  ALU compare result for conditional branches, valid in WB.
REQ-011 mem_gnt  in  1  memory accepted the current request.
REQ-012 mem_rvalid  in  1  memory response (read data or store acknowledge).
REQ-013 mem_req  out  1  memory request, held until granted.
REQ-014 mem_we  out  1  request is a write.
REQ-015 mem_addr_sel  out  1  address source: 0 PC, 1 ALU result.
REQ-016 ir_we  out  1  instruction-register load strobe.
REQ-017 rf_we  out  1  register-file write enable.
REQ-018 pc_we  out  1  PC update strobe.
REQ-019 pc_sel  out  1  next PC: 0 PC+4, 1 branch/jump target.
REQ-020 state  out  3  current FSM state encoding.
REQ-021 trap  out  1  sticky fault indication.
REQ-022 retire_cnt  out  CNT_W  count of retired instructions.

Function
REQ-023 The FSM has states IDLE, FETCH, DECODE, EXEC, MEM, WB and TRAP.
REQ-024 IDLE goes to FETCH on the cycle after start=1 and otherwise holds.
REQ-025 FETCH drives mem_req=1 (mem_addr_sel=0, mem_we=0) until mem_gnt=1 is sampled, then deasserts mem_req and waits for mem_rvalid.
REQ-026 In FETCH, mem_rvalid=1 after grant produces a one-cycle ir_we=1, and the FSM goes to DECODE.
REQ-027 mem_rvalid is ignored in any cycle before the grant, including the grant cycle itself.
REQ-028 DECODE lasts one cycle and goes to TRAP when dec_reg_write, dec_mem_write and dec_branch are all zero (illegal instruction); otherwise it goes to EXEC.
REQ-029 EXEC lasts one cycle and goes to MEM when dec_load or dec_mem_write is set; otherwise it goes to WB.
REQ-030 MEM follows the FETCH handshake with mem_addr_sel=1 and mem_we=dec_mem_write, and goes to WB on mem_rvalid.
REQ-031 WB lasts one cycle with rf_we=dec_reg_write, pc_we=1, pc_sel=(dec_branch==001 or 010) or (dec_branch[2] and br_taken), and retire_cnt+1 (wrapping modulo 2^CNT_W); it then goes to FETCH.
REQ-032 An 8-bit timer clears when mem_req rises and counts every cycle until mem_rvalid is accepted; reaching TIMEOUT without a response goes to TRAP.
REQ-033 TRAP is sticky: trap=1, all strobes and mem_req are 0, and only reset exits it.
REQ-034 rf_we, pc_we and ir_we are never asserted outside WB or the accepting FETCH cycle.
REQ-035 Minimum latency with zero-wait memory (grant in the request cycle, rvalid the next cycle) is 5 cycles per ALU or branch instruction and 7 per load or store.

Reset
REQ-036 rst_n=0 asynchronously forces state=IDLE, clears retire_cnt and the timer, clears trap, and drives every output to 0.
REQ-037 Reset asserted mid-transaction drops mem_req immediately, and any later mem_rvalid is ignored until a new request has been granted.

Structure
REQ-038 A shared package holds the state encoding (IDLE=0, FETCH=1, DECODE=2, EXEC=3, MEM=4, WB=5, TRAP=6), the branch codes and the default TIMEOUT.
REQ-039 One sub-module, seq_mem_port, implements the req/gnt/rvalid handshake and timer; it is instantiated once and shared by FETCH and MEM.

Verification
REQ-040 Zero-wait add: start=1, gnt same cycle, rvalid next cycle, dec_reg_write=1 -> ir_we at cycle 2, rf_we=1 and pc_we=1 with pc_sel=0 at cycle 5, retire_cnt=1.
REQ-041 Store with 3-cycle gnt delay: dec_mem_write=1 -> mem_req held 4 cycles in MEM, mem_we=1, mem_addr_sel=1, and rf_we=0 in WB.
REQ-042 Branch code 100 with br_taken=0, then 100 with br_taken=1, then 001 -> pc_sel=0, 1, 1 in the three WB cycles.
REQ-043 mem_rvalid never arrives, TIMEOUT=4 -> trap=1 four cycles after mem_req rises, and the FSM stays in TRAP with start pulsed.
REQ-044 All-zero decode -> DECODE to TRAP with no rf_we or pc_we, and retire_cnt is unchanged.
REQ-045 rst_n low during a MEM wait with a stale rvalid after release -> state=IDLE and no ir_we or rf_we.
